regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (a3/we3/wd) among NUM_REQ writeback requesters, e.g. ALU, load unit and multi-cycle mul/div.
- Arbitration is round-robin with valid/ready handshakes.
- The grant goes into a one-entry output register that drives the register-file write port directly.
- The block sits between the execute/memory units and the register file.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ x ADDR_W  destination register per requester
req_data  input  NUM_REQ x DATA_W  write data per requester
req_ready  output  NUM_REQ  one-hot grant; transfer occurs when valid && ready
stall  input  1  pipeline freeze; no grants while high
a3  output  ADDR_W  register-file write address (registered)
we3  output  1  register-file write enable (registered)
wd  output  DATA_W  register-file write data (registered)
busy  output  1  high when any req_valid is high and not granted this cycle

Behaviour:
- Reset (async, rst=1): a3=0, we3=0, wd=0, round-robin pointer=0, req_ready=0.
- Grant logic (combinational):
  - If stall=0, req_ready is one-hot: it selects the first valid requester at or after the pointer, scanning upward and wrapping from NUM_REQ-1 to 0.
  - req_ready=0 when stall=1 or no request is valid.
- Output stage: at each posedge, if a grant occurred:
  - a3 and wd take the granted request's address and data.
  - we3=1 unless req_addr==0, in which case the write is accepted, acknowledged and dropped (we3=0).
  - With no grant, we3=0; a3 and wd hold their values.
- Latency: exactly 1 cycle from handshake to we3; the register file commits on the following edge.
- Throughput: one write per cycle. A requester holding req_valid is granted within NUM_REQ cycles when stall stays low.
- Pointer update: after a grant to index i, pointer = (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Requester rules:
  - req_addr and req_data must be stable while req_valid=1 and ready=0.
  - Dropping valid before a grant is allowed; the block keeps no memory of it.
- Same-destination collision: two requesters targeting the same register in one cycle are serialized in pointer order. The later grant wins the final register value.
- Stall mid-request: no grants. The output register still presents the previous cycle's grant, since the handshake already completed. The pointer holds.
- rst asserted mid-operation: pending output write is lost (we3 forced 0 immediately) and the pointer returns to 0.
- busy = |req_valid & ~req_ready.

Optional Feature:
Macro WB_ARB_TRACE_EN.
- Defined: every posedge where we3 is about to be set prints $display with time, granted index, address and data. A grant to x0 prints a "dropped x0" line.
- Undefined: no display statements are compiled.
- Functional behaviour is identical either way.

Decomposition:
- Shared package riscv_structures gains:
  - typedef wb_req_t (addr [ADDR_W-1:0], data [DATA_W-1:0])
  - localparams REG_ADDR_W=5 and XLEN=32, used as parameter defaults.
- One sub-module, rr_arbiter:
  - Parameterized by N.
  - Inputs: request vector, enable (~stall), clk, rst.
  - Outputs: one-hot grant.
  - Owns the pointer register.
- The top level muxes wb_req_t by grant and owns the output register.

Test Plan:
- Reset: rst=1 mid-stream with we3=1 pending -> we3=0, a3=0, wd=0 immediately; the first grant after release goes to requester 0.
- Single requester: req1 valid, addr=5, data=0xDEADBEEF -> ready[1]=1 in cycle 0; we3=1, a3=5, wd=0xDEADBEEF in cycle 1.
- All three valid for 6 cycles:
  - Grants go 0,1,2,0,1,2 with the pointer starting at 0.
  - we3 is high for 6 consecutive cycles, each one cycle after its grant.
- x0 write: req0 addr=0, data=0x1234 -> ready[0]=1; next cycle we3=0; the register file's x0 reads 0.
- Stall: all valid, stall=1 for 3 cycles -> req_ready=0, busy=1, we3=0 after the first stalled edge, pointer unchanged. On release, grant goes to the pre-stall pointer index.
- Collision: req0 addr=7 data=0x11 and req2 addr=7 data=0x22 in the same cycle, pointer=0 -> req0 writes first, then req2; x7 ends at 0x22.

Source files
------------

// File: rtl/riscv_structures_pkg.sv
// Shared RISC-V datapath types and widths used by the writeback arbiter.
package riscv_structures;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_vld
);
  logic [PW-1:0] r_ptr;
  logic [N-1:0]  w_grant;
  logic [PW-1:0] w_idx;
  logic          w_vld;

  always_comb begin
    int j;
    j       = 0;
    w_grant = '0;
    w_idx   = '0;
    w_vld   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(r_ptr) + k) % N;
      if (!w_vld && i_en && !rst && i_req[j]) begin
        w_grant[j] = 1'b1;
        w_idx      = PW'(j);
        w_vld      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else if (w_vld) r_ptr <= (w_idx == PW'(N-1)) ? '0 : w_idx + 1'b1;
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;
  assign o_vld   = w_vld;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback requesters.
// Define WB_ARB_TRACE_EN to print every accepted writeback.
module regfile_wb_arbiter
  import riscv_structures::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = XLEN,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             stall,
  output logic [ADDR_W-1:0]                a3,
  output logic                             we3,
  output logic [DATA_W-1:0]                wd,
  output logic                             busy
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_p_t;

  logic [NUM_REQ-1:0] w_grant;
  logic [PW-1:0]      w_idx;
  logic               w_vld;
  wb_req_p_t          w_sel;
  logic [ADDR_W-1:0]  r_a3;
  logic               r_we3;
  logic [DATA_W-1:0]  r_wd;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (req_valid),
    .i_en    (~stall),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_vld   (w_vld)
  );

  assign w_sel.addr = req_addr[w_idx];
  assign w_sel.data = req_data[w_idx];

  // Writes to x0 are handshaken normally but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a3  <= '0;
      r_we3 <= 1'b0;
      r_wd  <= '0;
    end else if (w_vld) begin
      r_a3  <= w_sel.addr;
      r_wd  <= w_sel.data;
      r_we3 <= (w_sel.addr != '0);
    end else begin
      r_we3 <= 1'b0;
    end
  end

`ifdef WB_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && w_vld) begin
      if (w_sel.addr == '0)
        $display("%0t wb_arb: req %0d dropped x0 data=%h", $time, w_idx, w_sel.data);
      else
        $display("%0t wb_arb: req %0d x%0d <= %h", $time, w_idx, w_sel.addr, w_sel.data);
    end
  end
`endif

  assign req_ready = w_grant;
  assign a3        = r_a3;
  assign we3       = r_we3;
  assign wd        = r_wd;
  assign busy      = |(req_valid & ~w_grant);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed vector table, reset/x0/collision sequences, random vs model.
module tb_regfile_wb_arbiter;
  localparam int N = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid;
  logic [N-1:0][4:0]     req_addr;
  logic [N-1:0][31:0]    req_data;
  logic [N-1:0]          req_ready;
  logic                  stall;
  logic [4:0]            a3;
  logic                  we3;
  logic [31:0]           wd;
  logic                  busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .stall(stall),
    .a3(a3), .we3(we3), .wd(wd), .busy(busy)
  );

  // Register file consuming the write port; x0 is hardwired to zero.
  always_ff @(posedge clk) if (we3 && a3 != 5'd0) rf[a3] <= wd;

  typedef struct {
    logic [N-1:0]       vld;
    logic [N-1:0][4:0]  addr;
    logic [N-1:0][31:0] data;
    logic               stl;
    logic [N-1:0]       rdy;
    logic               we3;
    logic [4:0]         a3;
    logic [31:0]        wd;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0][4:0] ad,
                              input logic [N-1:0][31:0] dt, input logic s,
                              input logic [N-1:0] r, input logic w, input logic [4:0] a,
                              input logic [31:0] d);
    vec_t t;
    t.vld = v; t.addr = ad; t.data = dt; t.stl = s;
    t.rdy = r; t.we3 = w; t.a3 = a; t.wd = d;
    return t;
  endfunction

  // Reference model state
  int          m_ptr;
  logic [4:0]  m_a3;
  logic        m_we3;
  logic [31:0] m_wd;

  task automatic model_step(input string nm);
    int g;
    logic [N-1:0] er;
    g = -1;
    if (!stall)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    #1;
    chk({nm, ".ready"}, 64'(req_ready), 64'(er));
    chk({nm, ".busy"}, 64'(busy), 64'(|(req_valid & ~er)));
    @(posedge clk); #1;
    if (g >= 0) begin
      m_a3  = req_addr[g];
      m_wd  = req_data[g];
      m_we3 = (req_addr[g] != 5'd0);
      m_ptr = (g + 1) % N;
    end else m_we3 = 1'b0;
    chk({nm, ".we3"}, 64'(we3), 64'(m_we3));
    chk({nm, ".a3"}, 64'(a3), 64'(m_a3));
    chk({nm, ".wd"}, 64'(wd), 64'(m_wd));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0][4:0]  A3;
    logic [N-1:0][31:0] D3;
    logic [N-1:0][4:0]  A7;
    logic [N-1:0][31:0] D7;
    logic [N-1:0][4:0]  AZ;
    logic [N-1:0][31:0] DZ;
    A3 = {5'd3, 5'd2, 5'd1};
    D3 = {32'hA2, 32'hA1, 32'hA0};
    A7 = {5'd7, 5'd0, 5'd7};
    D7 = {32'h22, 32'h0, 32'h11};
    AZ = {5'd0, 5'd5, 5'd0};
    DZ = {32'h0, 32'hDEADBEEF, 32'h1234};

    tbl[0]  = mk(3'b111, A3, D3, 0, 3'b001, 1, 5'd1, 32'hA0);
    tbl[1]  = mk(3'b111, A3, D3, 0, 3'b010, 1, 5'd2, 32'hA1);
    tbl[2]  = mk(3'b111, A3, D3, 0, 3'b100, 1, 5'd3, 32'hA2);
    tbl[3]  = mk(3'b111, A3, D3, 0, 3'b001, 1, 5'd1, 32'hA0);
    tbl[4]  = mk(3'b111, A3, D3, 0, 3'b010, 1, 5'd2, 32'hA1);
    tbl[5]  = mk(3'b111, A3, D3, 0, 3'b100, 1, 5'd3, 32'hA2);
    tbl[6]  = mk(3'b010, AZ, DZ, 0, 3'b010, 1, 5'd5, 32'hDEADBEEF);
    tbl[7]  = mk(3'b001, AZ, DZ, 0, 3'b001, 0, 5'd0, 32'h1234);
    tbl[8]  = mk(3'b000, AZ, DZ, 0, 3'b000, 0, 5'd0, 32'h1234);
    tbl[9]  = mk(3'b111, A3, D3, 1, 3'b000, 0, 5'd0, 32'h1234);
    tbl[10] = mk(3'b111, A3, D3, 1, 3'b000, 0, 5'd0, 32'h1234);
    tbl[11] = mk(3'b111, A3, D3, 1, 3'b000, 0, 5'd0, 32'h1234);
    tbl[12] = mk(3'b111, A3, D3, 0, 3'b010, 1, 5'd2, 32'hA1);
    tbl[13] = mk(3'b100, A3, D3, 0, 3'b100, 1, 5'd3, 32'hA2);
    tbl[14] = mk(3'b101, A7, D7, 0, 3'b001, 1, 5'd7, 32'h11);
    tbl[15] = mk(3'b100, A7, D7, 0, 3'b100, 1, 5'd7, 32'h22);
    tbl[16] = mk(3'b000, A7, D7, 0, 3'b000, 0, 5'd7, 32'h22);

    rst = 1'b1; stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset.we3", 64'(we3), 64'(0));
    chk("reset.a3", 64'(a3), 64'(0));
    chk("reset.wd", 64'(wd), 64'(0));
    req_valid = 3'b111;
    #1;
    chk("reset.ready", 64'(req_ready), 64'(0));
    req_valid = '0;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      req_valid = tbl[i].vld; req_addr = tbl[i].addr;
      req_data = tbl[i].data; stall = tbl[i].stl;
      #1;
      chk({nm, ".ready"}, 64'(req_ready), 64'(tbl[i].rdy));
      chk({nm, ".busy"}, 64'(busy), 64'(|(tbl[i].vld & ~tbl[i].rdy)));
      @(posedge clk); #1;
      chk({nm, ".we3"}, 64'(we3), 64'(tbl[i].we3));
      chk({nm, ".a3"}, 64'(a3), 64'(tbl[i].a3));
      chk({nm, ".wd"}, 64'(wd), 64'(tbl[i].wd));
    end
    chk("rf.x7", 64'(rf[7]), 64'h22);
    chk("rf.x5", 64'(rf[5]), 64'hDEADBEEF);
    chk("rf.x0", 64'(rf[0]), 64'h0);

    // Reset asserted while a write is pending on the port
    req_valid = 3'b010; req_addr = {5'd0, 5'd9, 5'd0}; req_data = {32'h0, 32'h55, 32'h0};
    @(posedge clk); #1;
    chk("midrst.pre_we3", 64'(we3), 64'(1));
    rst = 1'b1;
    #1;
    chk("midrst.we3", 64'(we3), 64'(0));
    chk("midrst.a3", 64'(a3), 64'(0));
    chk("midrst.wd", 64'(wd), 64'(0));
    chk("midrst.ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    req_valid = 3'b111; req_addr = A3; req_data = D3;
    rst = 1'b0;
    #1;
    chk("postrst.ready", 64'(req_ready), 64'(3'b001));

    m_ptr = 0; m_a3 = 5'd0; m_we3 = 1'b0; m_wd = 32'h0;
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int r = 0; r < N; r++) begin
        req_addr[r] = 5'($urandom_range(0, 3));
        req_data[r] = $urandom;
      end
      stall = ($urandom_range(0, 9) == 0);
      model_step($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
